// File: rtl/rfile_pkg.sv
// Shared constants and types for the general-purpose register file.
//   RF_DATA_W  register width in bits
//   RF_ADDR_W  register address width
//   RF_DEPTH   number of registers (2**RF_ADDR_W)
//   rf_addr_t  register address type
//   rf_data_t  register data type
package rfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DEPTH  = 1 << RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rfile_rdport.sv
// One combinational read port of the register file.
// It selects the addressed register and optionally forwards the in-flight
// write data. When R0_ZERO is set, it forces register 0 to read as zero.
// Ports:
//   addr        read address
//   regs        flattened register storage, entry i = register i
//   write_en    write enable of the write port (used for forwarding)
//   write_reg   write address of the write port (used for forwarding)
//   write_data  write data of the write port (forwarded value)
//   data        read result
module rfile_rdport
    import rfile_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int R0_ZERO = 0,
    parameter int BYPASS  = 0
) (
    input  logic [ADDR_W-1:0]                      addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]     regs,
    input  logic                                   write_en,
    input  logic [ADDR_W-1:0]                      write_reg,
    input  logic [DATA_W-1:0]                      write_data,
    output logic [DATA_W-1:0]                      data
);

    always_comb begin
        // NOTE: assign a default first so every path drives data; a missing
        // branch in always_comb would otherwise infer a latch.
        data = regs[addr];
        if (BYPASS != 0 && write_en && write_reg == addr) begin
            data = write_data;
        end
        // The zero register wins over forwarding: a dropped write must never
        // become visible, not even for one cycle.
        if (R0_ZERO != 0 && addr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/rfile.sv
// General-purpose register file for the CPU datapath: 2**ADDR_W registers of
// DATA_W bits, two combinational read ports and one synchronous write port.
// Ports:
//   clk          clock; writes happen on the rising edge
//   rst          asynchronous active-low reset, clears every register
//   read_reg_1   read port 1 address
//   read_reg_2   read port 2 address
//   write_en     write enable, sampled at posedge clk
//   write_reg    write address
//   write_data   write data
//   read_data_1  contents of register read_reg_1
//   read_data_2  contents of register read_reg_2
module rfile
    import rfile_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int R0_ZERO = 0,
    parameter int BYPASS  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic                         write_ok;

    // With a hardwired zero register, writes to address 0 are dropped at the
    // source, so the storage for register 0 simply stays at its reset value.
    assign write_ok = write_en && !(R0_ZERO != 0 && write_reg == '0);

    // NOTE: the whole array sits on the async reset because the datapath
    // relies on every register reading as zero after reset; that rules out
    // mapping this storage onto a RAM macro without reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (write_ok) begin
            // NOTE: non-blocking so same-edge readers of regs see the old value.
            regs[write_reg] <= write_data;
        end
    end

    rfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .R0_ZERO(R0_ZERO),
        .BYPASS (BYPASS)
    ) u_rdport_1 (
        .addr      (read_reg_1),
        .regs      (regs),
        .write_en  (write_en),
        .write_reg (write_reg),
        .write_data(write_data),
        .data      (read_data_1)
    );

    rfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .R0_ZERO(R0_ZERO),
        .BYPASS (BYPASS)
    ) u_rdport_2 (
        .addr      (read_reg_2),
        .regs      (regs),
        .write_en  (write_en),
        .write_reg (write_reg),
        .write_data(write_data),
        .data      (read_data_2)
    );

endmodule

// File: tb/tb_rfile.sv
// Directed testbench for rfile. Three instances share the same stimulus:
//   dut_plain  R0_ZERO=0 BYPASS=0
//   dut_byp    R0_ZERO=0 BYPASS=1
//   dut_r0z    R0_ZERO=1 BYPASS=0
module tb_rfile;

    logic        clk;
    logic        rst;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    logic [31:0] plain_rd1, plain_rd2;
    logic [31:0] byp_rd1,   byp_rd2;
    logic [31:0] r0z_rd1,   r0z_rd2;

    int total = 0;
    int bad   = 0;

    rfile #(.R0_ZERO(0), .BYPASS(0)) dut_plain (
        .clk(clk), .rst(rst),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .read_data_1(plain_rd1), .read_data_2(plain_rd2)
    );

    rfile #(.R0_ZERO(0), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .read_data_1(byp_rd1), .read_data_2(byp_rd2)
    );

    rfile #(.R0_ZERO(1), .BYPASS(0)) dut_r0z (
        .clk(clk), .rst(rst),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .read_data_1(r0z_rd1), .read_data_2(r0z_rd2)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] init_vals [4];

    initial begin
        init_vals[0] = 32'h55;
        init_vals[1] = 32'h75;
        init_vals[2] = 32'hD5;
        init_vals[3] = 32'h57;

        rst        = 1'b0;
        read_reg_1 = '0;
        read_reg_2 = '0;
        write_en   = 1'b0;
        write_reg  = '0;
        write_data = '0;

        // Reset held for 4 cycles; every address reads 0 on both ports.
        repeat (4) tick();
        for (int a = 0; a < 32; a++) begin
            read_reg_1 = 5'(a);
            read_reg_2 = 5'(31 - a);
            #1;
            check($sformatf("reset_p1_a%0d", a), plain_rd1, 32'h0);
            check($sformatf("reset_p2_a%0d", 31 - a), plain_rd2, 32'h0);
        end
        check("reset_byp", byp_rd1, 32'h0);
        check("reset_r0z", r0z_rd1, 32'h0);
        rst = 1'b1;

        // Four consecutive writes r0..r3.
        write_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_reg  = 5'(i);
            write_data = init_vals[i];
            tick();
        end
        write_en = 1'b0;

        read_reg_1 = 5'd0; read_reg_2 = 5'd1; #1;
        check("rd_r0_plain", plain_rd1, 32'h55);
        check("rd_r1_plain", plain_rd2, 32'h75);
        check("rd_r0_byp",   byp_rd1,   32'h55);
        check("rd_r0_r0z",   r0z_rd1,   32'h0);
        check("rd_r1_r0z",   r0z_rd2,   32'h75);

        read_reg_1 = 5'd2; read_reg_2 = 5'd3; #1;
        check("rd_r2_plain", plain_rd1, 32'hD5);
        check("rd_r3_plain", plain_rd2, 32'h57);

        // write_en=0 must leave r3 untouched.
        write_reg  = 5'd3;
        write_data = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("we0_r3_plain", plain_rd2, 32'h57);
        check("we0_r3_byp",   byp_rd2,   32'h57);

        // Both ports on the same register.
        read_reg_1 = 5'd2; read_reg_2 = 5'd2; #1;
        check("same_p1", plain_rd1, 32'hD5);
        check("same_p2", plain_rd2, 32'hD5);

        // Same-cycle write r1=0xAA while reading r1.
        read_reg_1 = 5'd1;
        write_en   = 1'b1;
        write_reg  = 5'd1;
        write_data = 32'hAA;
        #1;
        check("wr_rd_before_plain", plain_rd1, 32'h75);
        check("wr_rd_before_byp",   byp_rd1,   32'hAA);
        check("wr_rd_before_r0z",   r0z_rd1,   32'h75);
        tick();
        write_en = 1'b0;
        #1;
        check("wr_rd_after_plain", plain_rd1, 32'hAA);
        check("wr_rd_after_byp",   byp_rd1,   32'hAA);

        // R0_ZERO: write r0=0x55 is dropped on dut_r0z only.
        write_en   = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'h55;
        read_reg_1 = 5'd0;
        tick();
        write_en = 1'b0;
        #1;
        check("r0z_wr0_r0z",   r0z_rd1,   32'h0);
        check("r0z_wr0_plain", plain_rd1, 32'h55);

        // Reset between edges clears everything at once.
        #10;
        rst        = 1'b0;
        read_reg_1 = 5'd1;
        read_reg_2 = 5'd3;
        #1;
        check("midrst_r1_plain", plain_rd1, 32'h0);
        check("midrst_r3_plain", plain_rd2, 32'h0);
        check("midrst_r1_byp",   byp_rd1,   32'h0);
        check("midrst_r3_r0z",   r0z_rd2,   32'h0);

        // Writes are ignored while reset is held.
        write_en   = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'h1234_5678;
        read_reg_1 = 5'd5;
        tick();
        write_en = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_wr_ignored", plain_rd1, 32'h0);

        // A fresh write after reset release lands normally.
        write_en   = 1'b1;
        write_reg  = 5'd31;
        write_data = 32'hDEAD_BEEF;
        read_reg_2 = 5'd31;
        tick();
        write_en = 1'b0;
        #1;
        check("post_rst_r31", plain_rd2, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
